// File: rtl/slice_subtractor_16_pkg.sv
// Shared constants and state encoding for the slice-serial 16-bit subtractor.
package slice_subtractor_16_pkg;
  localparam int WIDTH      = 16;
  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/slice_subtractor_16_if.sv
// Request/result bundle for slice_subtractor_16; the master drives operands, the slave returns results.
interface slice_subtractor_16_if;
  import slice_subtractor_16_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
endinterface

// File: rtl/slice_subtractor_16_sub4_slice.sv
// Combinational 4-bit subtract-with-borrow: o_d = i_x - i_y - i_bi, o_bo set on underflow.
module sub4_slice
  import slice_subtractor_16_pkg::*;
(
  input  logic [SLICE_W-1:0] i_x,
  input  logic [SLICE_W-1:0] i_y,
  input  logic               i_bi,
  output logic [SLICE_W-1:0] o_d,
  output logic               o_bo
);
  logic [SLICE_W:0] w_full;

  // One extra bit catches the wrap below zero, which is exactly the borrow-out.
  assign w_full = {1'b0, i_x} - {1'b0, i_y} - {{SLICE_W{1'b0}}, i_bi};
  assign o_d    = w_full[SLICE_W-1:0];
  assign o_bo   = w_full[SLICE_W];
endmodule

// File: rtl/slice_subtractor_16.sv
// Slice-serial 16-bit subtractor: one 4-bit slice per clock through a single shared sub4_slice.
// Optional flag outputs (zero, ovf) are enabled by defining SLICE_SUB_FLAGS_EN.
module slice_subtractor_16
  import slice_subtractor_16_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  slice_subtractor_16_if.slave  bus
);
  localparam int ACC_W = WIDTH - SLICE_W;

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_zero;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [SLICE_W-1:0] w_x;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W-1:0] w_d;
  logic               w_bo;
  logic [WIDTH-1:0]   w_diffFull;
  logic               w_zeroNext;
  logic               w_ovfNext;

  assign w_x = r_a[{r_cnt, 2'b00} +: SLICE_W];
  assign w_y = r_b[{r_cnt, 2'b00} +: SLICE_W];

  sub4_slice u_slice (
    .i_x  (w_x),
    .i_y  (w_y),
    .i_bi (r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  // Only meaningful on the final slice, when w_d is the top nibble.
  assign w_diffFull = {w_d, r_acc};

`ifdef SLICE_SUB_FLAGS_EN
  assign w_zeroNext = (w_diffFull == '0);
  assign w_ovfNext  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diffFull[WIDTH-1] != r_a[WIDTH-1]);
`else
  assign w_zeroNext = 1'b0;
  assign w_ovfNext  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= 2'd0;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 2'd1;
          // Lower nibbles stay private in r_acc; diff only changes on the final slice.
          case (r_cnt)
            2'd0: r_acc[3:0]  <= w_d;
            2'd1: r_acc[7:4]  <= w_d;
            2'd2: r_acc[11:8] <= w_d;
            default: begin
              r_diff  <= w_diffFull;
              r_bout  <= w_bo;
              r_zero  <= w_zeroNext;
              r_ovf   <= w_ovfNext;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          endcase
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;
endmodule

// File: doc/slice_subtractor_16.md
SLICE_SUBTRACTOR_16 -- requirements
Module: slice_subtractor_16

Interface
REQ-001 SHALL have no parameters; width fixed at 16 bits, processed as four 4-bit slices.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 a  input  16  minuend.
REQ-007 b  input  16  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 diff  output  16  a - b - bin, modulo 2^16.
REQ-012 bout  output  1  borrow-out, high when unsigned a < b + bin.
REQ-013 zero  output  1  diff == 0.
REQ-014 ovf  output  1  two's-complement overflow of a - b - bin.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 at an edge latches a, b and bin, clears the slice counter, and moves to RUN.
REQ-017 RUN: each edge computes one 4-bit slice, nibble 0 first, using the registered borrow chain; the counter runs 0..3.
REQ-018 The edge that computes slice 3 SHALL move to DONE and register diff, bout, zero and ovf.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; if start=1 in DONE, it SHALL instead accept the new operands and enter RUN, with no idle cycle.
REQ-020 Latency: start sampled at edge k, done high during the cycle after edge k+4.
REQ-021 start in RUN SHALL be ignored, and the operand registers SHALL not change.
REQ-022 diff, bout, zero and ovf SHALL hold their last result until the next DONE; intermediate slices SHALL not be visible on diff.
REQ-023 ovf SHALL be (a[15] != b[15]) && (diff[15] != a[15]), evaluated with bin included in diff.
REQ-024 Changes on a, b or bin after the start edge SHALL not affect the result.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, zero=0, ovf=0, counter=0 and operand registers=0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 The first start SHALL be sampled at the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SLICE_SUB_FLAGS_EN defined: zero and ovf SHALL be computed per REQ-013, REQ-014 and REQ-023.
REQ-029 Macro SLICE_SUB_FLAGS_EN undefined: zero and ovf ports SHALL remain and be driven constant 0; diff, bout and timing SHALL be unchanged.

Structure
REQ-030 A shared package SHALL hold WIDTH=16, SLICE_W=4, NUM_SLICES=4 and the state enum {IDLE, RUN, DONE}.
REQ-031 A combinational sub-module sub4_slice SHALL compute the 4-bit x - y - bi, giving a 4-bit difference and a borrow-out.
REQ-032 A single sub4_slice instance SHALL be reused across cycles and fed by nibble muxes on the counter.

Verification
REQ-033 a=0x24D7, b=0x0712, bin=0 -> diff=0x1DC5, bout=0, zero=0, ovf=0; done high 5 cycles after the start edge.
REQ-034 a=0xFDE8, b=0x0712, bin=0 -> diff=0xF6D6, bout=0, ovf=0; then a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1; a=0x1234, b=0x1233, bin=1 -> diff=0x0000, zero=1, bout=0.
REQ-036 start held high continuously with new operands at each DONE -> results every 5 cycles; start pulses in RUN ignored, results match the operands latched at acceptance.
REQ-037 rst_n pulsed low during RUN slice 2 -> all outputs 0 immediately, no done pulse; the next start completes correctly.
REQ-038 Run all scenarios with SLICE_SUB_FLAGS_EN undefined -> zero=ovf=0 throughout; diff, bout and timing unchanged.
